// File: rtl/vert_servo_pwm_if.sv
// Vertical servo PWM interface.
// Groups the move requests from the vertical sweep control with the servo
// driver's pulse, status flags, frame strobe and active position.
//   master : sweep control side (drives MOVE_UP/MOVE_DOWN, observes the rest)
//   slave  : servo driver side (samples MOVE_UP/MOVE_DOWN, drives the rest)
interface vert_servo_pwm_if #(
  parameter int unsigned CW = 21
);
  logic          MOVE_UP;
  logic          MOVE_DOWN;
  logic          PWM;
  logic          PWM_limit;
  logic          PWM_home;
  logic          FRAME_TICK;
  logic [CW-1:0] POS;

  modport master (
    output MOVE_UP, MOVE_DOWN,
    input  PWM, PWM_limit, PWM_home, FRAME_TICK, POS
  );

  modport slave (
    input  MOVE_UP, MOVE_DOWN,
    output PWM, PWM_limit, PWM_home, FRAME_TICK, POS
  );
endinterface

// File: rtl/vert_servo_pwm.sv
// Vertical-axis (elevation) servo driver.
// Produces a frame-based PWM pulse whose width is the commanded position and
// steps that position by STEP once per frame on request, clamped to
// [MIN_PULSE, MAX_PULSE].
// Ports:
//   CLK   - system clock
//   RST_N - asynchronous active-low reset
//   bus   - vert_servo_pwm_if.slave:
//             MOVE_UP/MOVE_DOWN  step requests, sampled on the last frame cycle
//             PWM                registered servo pulse
//             PWM_limit/PWM_home position at MAX_PULSE / MIN_PULSE
//             FRAME_TICK         strobe on the last cycle of each frame
//             POS                pulse width currently driven on PWM
module vert_servo_pwm #(
  parameter int unsigned PERIOD    = 2_000_000,
  parameter int unsigned MIN_PULSE = 50_000,
  parameter int unsigned MAX_PULSE = 250_000,
  parameter int unsigned STEP      = 1_000,
  parameter int unsigned RESET_POS = 50_000,
  parameter int unsigned CW        = 21
) (
  input  logic            CLK,
  input  logic            RST_N,
  vert_servo_pwm_if.slave bus
);

  localparam logic [CW-1:0] LAST      = CW'(PERIOD - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PERIOD - 2);
  localparam logic [CW-1:0] MIN_P     = CW'(MIN_PULSE);
  localparam logic [CW-1:0] MAX_P     = CW'(MAX_PULSE);
  localparam logic [CW-1:0] RESET_P   = CW'(RESET_POS);
  localparam logic [CW:0]   MIN_W     = (CW+1)'(MIN_PULSE);
  localparam logic [CW:0]   MAX_W     = (CW+1)'(MAX_PULSE);
  localparam logic [CW:0]   STEP_W    = (CW+1)'(STEP);
  localparam logic          RST_LIMIT = (RESET_POS == MAX_PULSE);
  localparam logic          RST_HOME  = (RESET_POS == MIN_PULSE);

  typedef enum logic {RUN, HOLD} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  // pos is only ever written on the wrap edge, so it is also the active pulse.
  logic [CW-1:0] pos, pos_next;
  logic [CW:0]   pos_ext, sum, diff;
  logic          last, up_req, down_req, outward;
  logic          pwm, tick, limit, home;

  always_comb begin
    last       = (count == LAST);
    count_next = last ? '0 : count + 1'b1;
    up_req     = bus.MOVE_UP & ~bus.MOVE_DOWN;
    down_req   = bus.MOVE_DOWN & ~bus.MOVE_UP;
    outward    = (up_req && pos == MAX_P) || (down_req && pos == MIN_P);
    pos_ext    = {1'b0, pos};
    sum        = pos_ext + STEP_W;
    // diff[CW] set means the subtraction went below zero.
    diff       = pos_ext - STEP_W;
    state_next = state;
    pos_next   = pos;
    if (last) begin
      state_next = outward ? HOLD : RUN;
      // Still pinned against the same limit: skip the adder, pos holds.
      if (!(state == HOLD && outward)) begin
        if (up_req) begin
          pos_next = (sum > MAX_W) ? MAX_P : sum[CW-1:0];
        end else if (down_req) begin
          pos_next = (diff[CW] || diff < MIN_W) ? MIN_P : diff[CW-1:0];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RUN;
      count <= '0;
      pos   <= RESET_P;
      pwm   <= 1'b0;
      tick  <= 1'b0;
      limit <= RST_LIMIT;
      home  <= RST_HOME;
    end else begin
      state <= state_next;
      count <= count_next;
      pwm   <= (count < pos);
      // Registered one cycle ahead so the strobe sits on count PERIOD-1.
      tick  <= (count == PRE_LAST);
      if (last) begin
        pos   <= pos_next;
        limit <= (pos_next == MAX_P);
        home  <= (pos_next == MIN_P);
      end
    end
  end

  assign bus.PWM        = pwm;
  assign bus.PWM_limit  = limit;
  assign bus.PWM_home   = home;
  assign bus.FRAME_TICK = tick;
  assign bus.POS        = pos;

endmodule

// File: doc/vert_servo_pwm.md
Name: vert_servo_pwm

Overview:
Vertical-axis servo driver. Generates the frame-based PWM pulse for the elevation servo and holds the commanded position. Steps the position up or down once per frame. Drives PWM_limit (servo at 180 degrees) and PWM_home (servo at 0 degrees) back to the vertical sweep control, which consumes PWM_limit to end the up-sweep.

Parameters:
PERIOD, 2_000_000, PWM frame length in CLK cycles (20 ms at 100 MHz)
MIN_PULSE, 50_000, pulse width in cycles at 0 degrees (0.5 ms)
MAX_PULSE, 250_000, pulse width in cycles at 180 degrees (2.5 ms)
STEP, 1_000, pulse-width change per frame when moving
RESET_POS, 50_000, position loaded at reset; must satisfy MIN_PULSE <= RESET_POS <= MAX_PULSE
CW, 21, counter/position width; must satisfy 2^CW > PERIOD

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
MOVE_UP  in  1  request +STEP at next frame boundary (from sweep control; CNT_D-driven)
MOVE_DOWN  in  1  request -STEP at next frame boundary
PWM  out  1  servo control pulse, registered
PWM_limit  out  1  registered; 1 while active position == MAX_PULSE
PWM_home  out  1  registered; 1 while active position == MIN_PULSE
FRAME_TICK  out  1  one-cycle strobe on last cycle of each frame
POS  out  CW  position currently being driven on PWM, in cycles

Behaviour:
- Reset (RST_N=0, asynchronous): frame counter=0, pos=RESET_POS, active pulse=RESET_POS, PWM=0, FRAME_TICK=0, PWM_limit=(RESET_POS==MAX_PULSE), PWM_home=(RESET_POS==MIN_PULSE).
- Release is synchronous to CLK: the first counted cycle is the first CLK edge with RST_N=1.
- Frame counter: counts 0..PERIOD-1 and wraps to 0.
- FRAME_TICK=1 exactly on the cycle registered at count PERIOD-1.
- PWM is registered and equals (count < active pulse) one cycle late.
- High time per frame is exactly the active pulse width; the period is exactly PERIOD.
- The active pulse loads from pos only at wrap (count PERIOD-1 -> 0). No mid-frame width change, no glitch.
- Position update, evaluated only at count PERIOD-1, with MOVE_UP/MOVE_DOWN sampled that cycle:
  - UP=1, DOWN=0: pos = min(pos+STEP, MAX_PULSE).
  - UP=0, DOWN=1: pos = max(pos-STEP, MIN_PULSE).
  - Both 1 or both 0: hold.
  - Saturation: no wrap-around, no overshoot when the range is not a multiple of STEP.
  - Arithmetic is done in CW+1 bits before clamping.
- Requests outside the boundary cycle are ignored; there is no latching.
- The new pos takes effect on PWM in the frame that starts immediately after the boundary.
- POS, PWM_limit and PWM_home all reflect the active pulse and update together on the wrap edge, i.e. the same cycle the new frame starts.
  - PWM_limit stays high for as long as the position remains at MAX_PULSE.
  - It drops on the first wrap after a DOWN step.
- MOVE_UP held while at MAX_PULSE: pos holds and PWM_limit stays 1.
- MOVE_DOWN held while at MIN_PULSE: pos holds and PWM_home stays 1.
- Reset mid-frame: PWM drops immediately; the counter restarts from 0 after release.
- Internal FSM: RUN and HOLD.
  - HOLD is entered when the active pulse is at a limit and the request pushes outward.
  - HOLD suppresses the adder and returns to RUN on any inward request or no request.
  - The FSM is observable only through the flag timing above.

Test Plan:
(Bench parameters: PERIOD=100, MIN_PULSE=10, MAX_PULSE=30, STEP=4, RESET_POS=10.)
1. Reset then idle for 3 frames:
   - PWM high for 10 of every 100 cycles.
   - FRAME_TICK every 100 cycles.
   - PWM_home=1, PWM_limit=0, POS=10.
2. MOVE_UP held continuously:
   - POS sequence per frame is 14, 18, 22, 26, 30, 30.
   - PWM_limit rises on the wrap edge where POS becomes 30 and stays 1.
   - PWM_home falls on the first wrap.
3. STEP=7, MOVE_UP held:
   - POS is 17, 24, 30 (clamped), with no overshoot.
   - Then MOVE_DOWN held: POS is 23, 16, 10, 10; PWM_home rises at 10.
4. MOVE_UP pulsed for 1 cycle mid-frame (count 50): POS unchanged.
   - Pulse exactly at count 99: POS +STEP in the next frame.
5. MOVE_UP and MOVE_DOWN both 1 at the boundary: POS holds and no flag changes.
6. RST_N low at count 5 of a 30-cycle pulse frame:
   - PWM falls asynchronously.
   - All outputs return to reset values.
   - The first post-release pulse is 10 cycles.
